// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt dispatcher: IME and dispatch
// state encodings, default vector layout and the handler-address helper.
package interrupt_pkg;

  typedef enum logic [1:0] {
    IME_OFF   = 2'd0,
    IME_ARMED = 2'd1,
    IME_ON    = 2'd2
  } ime_state_e;

  typedef enum logic [1:0] {
    DISP_IDLE = 2'd0,
    DISP_REQ  = 2'd1,
    DISP_VEC  = 2'd2
  } disp_state_e;

  localparam logic [15:0] DEFAULT_VECTOR_BASE   = 16'h0040;
  localparam logic [15:0] DEFAULT_VECTOR_STRIDE = 16'h0008;
  localparam logic [15:0] CANCELLED_VECTOR      = 16'h0000;

  function automatic logic [15:0] vector_of(input logic [15:0] base,
                                            input logic [15:0] stride,
                                            input logic [15:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/interrupt_dispatcher_if.sv
// CPU-side bundle of the interrupt dispatcher: decode strobes, dispatch
// handshake and the IE/IF register port on the I/O bus.
interface interrupt_dispatcher_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_EI;
  logic                  i_DI;
  logic                  i_RETI;
  logic                  i_Instr_Done;
  logic                  i_Ack;
  logic                  o_Irq;
  logic [15:0]           o_Vector;
  logic                  o_Vector_Valid;
  logic                  i_Bus_Enable;
  logic                  i_ReadWrite;
  logic                  i_Register_Select;
  logic [DATA_WIDTH-1:0] i_Bus;
  logic [DATA_WIDTH-1:0] o_Bus;

  modport master (
    output i_EI, i_DI, i_RETI, i_Instr_Done, i_Ack,
    output i_Bus_Enable, i_ReadWrite, i_Register_Select, i_Bus,
    input  o_Irq, o_Vector, o_Vector_Valid, o_Bus
  );

  modport slave (
    input  i_EI, i_DI, i_RETI, i_Instr_Done, i_Ack,
    input  i_Bus_Enable, i_ReadWrite, i_Register_Select, i_Bus,
    output o_Irq, o_Vector, o_Vector_Valid, o_Bus
  );
endinterface

// File: rtl/interrupt_dispatcher_priority_encoder.sv
// Lowest-set-bit priority encoder: one-hot grant, binary index and valid.
module priority_encoder #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] i_Vector,
  output logic [WIDTH-1:0] o_One_Hot,
  output logic [IDX_W-1:0] o_Index,
  output logic             o_Valid
);

  assign o_One_Hot = i_Vector & (~i_Vector + WIDTH'(1));
  assign o_Valid   = |i_Vector;

  // NOTE: the default before the loop keeps this purely combinational; any
  // path leaving o_Index unassigned would infer a latch.
  always_comb begin
    o_Index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_Vector[i]) o_Index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_dispatcher.sv
// Interrupt controller with IE/IF registers, delayed-EI master enable and a
// request/ack dispatch handshake. Define IRQ_EDGE_DETECT_EN for edge-triggered IF.
module interrupt_dispatcher
  import interrupt_pkg::*;
#(
  parameter int          NUM_SRC       = 5,
  parameter int          DATA_WIDTH    = 8,
  parameter logic [15:0] VECTOR_BASE   = DEFAULT_VECTOR_BASE,
  parameter logic [15:0] VECTOR_STRIDE = DEFAULT_VECTOR_STRIDE
) (
  input  logic                   i_Clk,
  input  logic                   i_nRst,
  input  logic                   i_Enable,
  input  logic [NUM_SRC-1:0]     i_Interrupt_Request,
  output logic                   o_Halt_Wake,
  interrupt_dispatcher_if.slave  cpu
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] ie_q, ie_d;
  logic [NUM_SRC-1:0] if_q, if_d;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] req_set;
  logic [NUM_SRC-1:0] grant_one_hot;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  ime_state_e         ime_q, ime_d;
  disp_state_e        state_q, state_d;
  logic [15:0]        vector_q, vector_d;
  logic               bus_wr, bus_rd;
  logic               dispatch;
  logic [DATA_WIDTH-1:0] rd_data;

  assign pending     = ie_q & if_q;
  assign o_Halt_Wake = |pending;
  assign bus_wr      = cpu.i_Bus_Enable &  cpu.i_ReadWrite;
  assign bus_rd      = cpu.i_Bus_Enable & ~cpu.i_ReadWrite;
  // DI in the same cycle as ack aborts the dispatch instead of completing it.
  assign dispatch    = (state_q == DISP_REQ) & cpu.i_Ack & ~cpu.i_DI;

  priority_encoder #(
    .WIDTH (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_Vector  (pending),
    .o_One_Hot (grant_one_hot),
    .o_Index   (grant_idx),
    .o_Valid   (grant_valid)
  );

`ifdef IRQ_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] hist_q;

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst)       hist_q <= '0;
    else if (i_Enable) hist_q <= i_Interrupt_Request;
  end

  assign req_set = i_Interrupt_Request & ~hist_q;
`else
  assign req_set = i_Interrupt_Request;
`endif

  // Requests are OR-ed in last so they win over a bus write or dispatch clear.
  always_comb begin
    ie_d     = ie_q;
    if_d     = if_q;
    vector_d = vector_q;
    if (bus_wr &&  cpu.i_Register_Select) ie_d = cpu.i_Bus[NUM_SRC-1:0];
    if (bus_wr && !cpu.i_Register_Select) if_d = cpu.i_Bus[NUM_SRC-1:0];
    if (dispatch) begin
      if_d     = if_d & ~grant_one_hot;
      vector_d = grant_valid ? vector_of(VECTOR_BASE, VECTOR_STRIDE, 16'(grant_idx))
                             : CANCELLED_VECTOR;
    end
    if_d = if_d | req_set;
  end

  always_comb begin
    ime_d = ime_q;
    if (cpu.i_DI || dispatch)                      ime_d = IME_OFF;
    else if (cpu.i_RETI)                           ime_d = IME_ON;
    else if (cpu.i_EI && ime_q == IME_OFF)         ime_d = IME_ARMED;
    else if (!cpu.i_EI && ime_q == IME_ARMED && cpu.i_Instr_Done) ime_d = IME_ON;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      ie_q     <= '0;
      if_q     <= '0;
      ime_q    <= IME_OFF;
      vector_q <= '0;
    end else if (i_Enable) begin
      ie_q     <= ie_d;
      if_q     <= if_d;
      ime_q    <= ime_d;
      vector_q <= vector_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst)       state_q <= DISP_IDLE;
    else if (i_Enable) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISP_IDLE: if (ime_q == IME_ON && |pending && cpu.i_Instr_Done) state_d = DISP_REQ;
      DISP_REQ: begin
        if (cpu.i_DI)       state_d = DISP_IDLE;
        else if (cpu.i_Ack) state_d = DISP_VEC;
      end
      DISP_VEC:  state_d = DISP_IDLE;
      default:   state_d = DISP_IDLE;
    endcase
  end

  always_comb begin
    cpu.o_Irq          = (state_q == DISP_REQ);
    cpu.o_Vector_Valid = (state_q == DISP_VEC);
    cpu.o_Vector       = vector_q;
  end

  always_comb begin
    rd_data = '1;
    rd_data[NUM_SRC-1:0] = cpu.i_Register_Select ? ie_q : if_q;
  end

  assign cpu.o_Bus = bus_rd ? rd_data : '0;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed self-checking bench for interrupt_dispatcher with hand-computed
// expectations; follows IRQ_EDGE_DETECT_EN for the held-request case.
module tb_interrupt_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [4:0] irq_req;
  logic       halt_wake;
  int         total;
  int         bad;
  logic [7:0] rd;

  interrupt_dispatcher_if #(.DATA_WIDTH(8)) bus_if ();

  interrupt_dispatcher #(
    .NUM_SRC       (5),
    .DATA_WIDTH    (8),
    .VECTOR_BASE   (16'h0040),
    .VECTOR_STRIDE (16'h0008)
  ) dut (
    .i_Clk               (clk),
    .i_nRst              (rst_n),
    .i_Enable            (enable),
    .i_Interrupt_Request (irq_req),
    .o_Halt_Wake         (halt_wake),
    .cpu                 (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_cycle(input logic ei, input logic di, input logic reti,
                           input logic done, input logic ack);
    bus_if.i_EI = ei; bus_if.i_DI = di; bus_if.i_RETI = reti;
    bus_if.i_Instr_Done = done; bus_if.i_Ack = ack;
    step();
    bus_if.i_EI = 0; bus_if.i_DI = 0; bus_if.i_RETI = 0;
    bus_if.i_Instr_Done = 0; bus_if.i_Ack = 0;
  endtask

  task automatic pulse_req(input logic [4:0] v);
    irq_req = v;
    step();
    irq_req = '0;
  endtask

  task automatic bus_write(input logic sel, input logic [7:0] data);
    bus_if.i_Bus_Enable = 1; bus_if.i_ReadWrite = 1;
    bus_if.i_Register_Select = sel; bus_if.i_Bus = data;
    step();
    bus_if.i_Bus_Enable = 0; bus_if.i_ReadWrite = 0; bus_if.i_Bus = '0;
  endtask

  task automatic bus_read(input logic sel, output logic [7:0] data);
    bus_if.i_Bus_Enable = 1; bus_if.i_ReadWrite = 0; bus_if.i_Register_Select = sel;
    #1;
    data = bus_if.o_Bus;
    bus_if.i_Bus_Enable = 0;
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 0; enable = 1; irq_req = '0;
    bus_if.i_EI = 0; bus_if.i_DI = 0; bus_if.i_RETI = 0;
    bus_if.i_Instr_Done = 0; bus_if.i_Ack = 0;
    bus_if.i_Bus_Enable = 0; bus_if.i_ReadWrite = 0;
    bus_if.i_Register_Select = 0; bus_if.i_Bus = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step();

    // Reset state
    check("rst_irq", 32'(bus_if.o_Irq), 32'h0);
    check("rst_vec", 32'(bus_if.o_Vector), 32'h0);
    check("rst_valid", 32'(bus_if.o_Vector_Valid), 32'h0);
    check("rst_wake", 32'(halt_wake), 32'h0);
    check("rst_bus_idle", 32'(bus_if.o_Bus), 32'h0);
    bus_read(0, rd); check("rst_if", 32'(rd), 32'hE0);
    bus_read(1, rd); check("rst_ie", 32'(rd), 32'hE0);

    // Two simultaneous requests: lowest index wins
    bus_write(1, 8'h1F);
    cpu_cycle(0, 0, 1, 0, 0);
    pulse_req(5'b10100);
    bus_read(0, rd); check("two_req_if", 32'(rd), 32'hF4);
    check("two_req_wake", 32'(halt_wake), 32'h1);
    check("no_irq_before_boundary", 32'(bus_if.o_Irq), 32'h0);
    cpu_cycle(0, 0, 0, 1, 0);
    check("irq_after_boundary", 32'(bus_if.o_Irq), 32'h1);
    step();
    check("irq_held", 32'(bus_if.o_Irq), 32'h1);
    cpu_cycle(0, 0, 0, 0, 1);
    check("vec_valid", 32'(bus_if.o_Vector_Valid), 32'h1);
    check("vec_src2", 32'(bus_if.o_Vector), 32'h0050);
    check("vec_irq_low", 32'(bus_if.o_Irq), 32'h0);
    bus_read(0, rd); check("if_after_ack", 32'(rd), 32'hF0);
    step();
    check("valid_strobe", 32'(bus_if.o_Vector_Valid), 32'h0);
    check("vec_hold", 32'(bus_if.o_Vector), 32'h0050);
    cpu_cycle(0, 0, 0, 1, 0);
    check("ime_off_after_ack", 32'(bus_if.o_Irq), 32'h0);

    // Priority is resolved at ack time
    cpu_cycle(0, 0, 1, 0, 0);
    cpu_cycle(0, 0, 0, 1, 0);
    check("prio_req", 32'(bus_if.o_Irq), 32'h1);
    pulse_req(5'b00010);
    cpu_cycle(0, 0, 0, 0, 1);
    check("prio_at_ack", 32'(bus_if.o_Vector), 32'h0048);
    bus_read(0, rd); check("prio_if", 32'(rd), 32'hF0);
    step();
    bus_write(0, 8'h00);

    // Delayed EI
    bus_write(1, 8'h01);
    pulse_req(5'b00001);
    cpu_cycle(1, 0, 0, 0, 0);
    check("ei_armed_no_irq", 32'(bus_if.o_Irq), 32'h0);
    cpu_cycle(0, 0, 0, 1, 0);
    check("ei_first_boundary", 32'(bus_if.o_Irq), 32'h0);
    cpu_cycle(0, 0, 0, 1, 0);
    check("ei_second_boundary", 32'(bus_if.o_Irq), 32'h1);
    cpu_cycle(0, 0, 0, 0, 1);
    check("ei_vec", 32'(bus_if.o_Vector), 32'h0040);
    check("ei_valid", 32'(bus_if.o_Vector_Valid), 32'h1);
    step();

    // Cancelled dispatch
    pulse_req(5'b00001);
    cpu_cycle(0, 0, 1, 0, 0);
    cpu_cycle(0, 0, 0, 1, 0);
    check("cancel_req", 32'(bus_if.o_Irq), 32'h1);
    bus_write(0, 8'h00);
    check("cancel_still_req", 32'(bus_if.o_Irq), 32'h1);
    cpu_cycle(0, 0, 0, 0, 1);
    check("cancel_valid", 32'(bus_if.o_Vector_Valid), 32'h1);
    check("cancel_vec", 32'(bus_if.o_Vector), 32'h0000);
    bus_read(0, rd); check("cancel_if", 32'(rd), 32'hE0);
    step();
    pulse_req(5'b00001);
    cpu_cycle(0, 0, 0, 1, 0);
    check("cancel_ime_off", 32'(bus_if.o_Irq), 32'h0);

    // DI while requesting
    cpu_cycle(0, 0, 1, 0, 0);
    cpu_cycle(0, 0, 0, 1, 0);
    check("di_req", 32'(bus_if.o_Irq), 32'h1);
    cpu_cycle(0, 1, 0, 0, 0);
    check("di_drops_irq", 32'(bus_if.o_Irq), 32'h0);
    check("di_no_valid", 32'(bus_if.o_Vector_Valid), 32'h0);
    bus_read(0, rd); check("di_if_kept", 32'(rd), 32'hE1);
    cpu_cycle(0, 0, 0, 1, 0);
    check("di_ime_off", 32'(bus_if.o_Irq), 32'h0);
    bus_write(0, 8'h00);

    // Request beats a same-cycle IF write
    pulse_req(5'b00101);
    irq_req = 5'b00010;
    bus_write(0, 8'h00);
    irq_req = '0;
    bus_read(0, rd); check("req_beats_write", 32'(rd), 32'hE2);
    bus_write(0, 8'h00);

    // Clock enable low freezes everything
    enable = 0;
    pulse_req(5'b00001);
    bus_write(1, 8'h1F);
    cpu_cycle(0, 0, 1, 1, 0);
    bus_read(0, rd); check("en_low_if", 32'(rd), 32'hE0);
    bus_read(1, rd); check("en_low_ie", 32'(rd), 32'hE1);
    check("en_low_irq", 32'(bus_if.o_Irq), 32'h0);
    enable = 1;

    // Held request line, IF cleared while held
    irq_req = 5'b00001;
    step(); step();
    bus_write(0, 8'h00);
    step();
`ifdef IRQ_EDGE_DETECT_EN
    bus_read(0, rd); check("held_edge_if", 32'(rd), 32'hE0);
`else
    bus_read(0, rd); check("held_level_if", 32'(rd), 32'hE1);
`endif
    repeat (6) step();
    irq_req = '0;
    step();
    bus_write(0, 8'h00);

    // Reset during the vector cycle
    bus_write(1, 8'h1F);
    pulse_req(5'b00011);
    cpu_cycle(0, 0, 1, 0, 0);
    cpu_cycle(0, 0, 0, 1, 0);
    cpu_cycle(0, 0, 0, 0, 1);
    check("pre_rst_valid", 32'(bus_if.o_Vector_Valid), 32'h1);
    rst_n = 0;
    #1;
    check("mid_rst_valid", 32'(bus_if.o_Vector_Valid), 32'h0);
    check("mid_rst_vec", 32'(bus_if.o_Vector), 32'h0);
    check("mid_rst_irq", 32'(bus_if.o_Irq), 32'h0);
    check("mid_rst_wake", 32'(halt_wake), 32'h0);
    bus_read(0, rd); check("mid_rst_if", 32'(rd), 32'hE0);
    rst_n = 1;
    step();
    check("post_rst_valid", 32'(bus_if.o_Vector_Valid), 32'h0);
    bus_write(1, 8'h01);
    pulse_req(5'b00001);
    cpu_cycle(0, 0, 0, 1, 0);
    check("post_rst_ime_off", 32'(bus_if.o_Irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/interrupt_dispatcher.md
# interrupt_dispatcher

Parametrised interrupt controller that generalises the existing 5-source IE/IF block to NUM_SRC sources and adds CPU dispatch. It owns the master enable (IME) with delayed-EI semantics, runs a request/acknowledge handshake with the CPU core, and returns the handler vector of the highest-priority pending source. It sits between the peripheral interrupt lines and the CPU sequencer, with its IE/IF registers on the I/O bus.

## Interface
- NUM_SRC, 5, number of interrupt sources; bit 0 has highest priority
- DATA_WIDTH, 8, I/O bus width; must be ≥ NUM_SRC
- VECTOR_BASE, 16'h0040, vector of source 0
- VECTOR_STRIDE, 16'h0008, vector spacing between sources
- i_Clk  in  1  single clock, rising edge
- i_nRst  in  1  asynchronous, active-low reset
- i_Enable  in  1  clock enable; low freezes all state
- i_Interrupt_Request  in  NUM_SRC  peripheral request lines
- i_EI / i_DI / i_RETI  in  1 each  one-cycle strobes from CPU decode
- i_Instr_Done  in  1  one-cycle strobe at instruction boundary
- i_Ack  in  1  CPU accepts dispatch (one-cycle strobe)
- o_Irq  out  1  dispatch request to CPU
- o_Vector  out  16  handler address, valid with o_Vector_Valid
- o_Vector_Valid  out  1  one-cycle strobe
- o_Halt_Wake  out  1  any enabled source pending, regardless of IME
- i_Bus_Enable, i_ReadWrite (0 read, 1 write), i_Register_Select (0 IF, 1 IE)  in  1 each
- i_Bus  in  DATA_WIDTH; o_Bus  out  DATA_WIDTH

## Operation
- Pending = IE & IF. o_Halt_Wake = |Pending (combinational).
- IF bit sets on request (see Configuration); cleared by bus write or by dispatch.
- Bus read: o_Bus = selected register in low NUM_SRC bits, upper bits read 1; o_Bus = 0 when not reading. Writes take low NUM_SRC bits.
- IME states: IME_OFF, IME_ARMED, IME_ON. EI: OFF→ARMED; ARMED→ON on next i_Instr_Done after the EI cycle. RETI: →ON immediately. DI: →OFF from any state. Dispatch ack: →OFF.
- Dispatch FSM: IDLE → REQ when IME_ON & |Pending & i_Instr_Done. REQ holds o_Irq until i_Ack. On i_Ack: snapshot lowest set bit of current Pending, clear that IF bit, go to VEC. VEC: o_Vector_Valid=1, o_Vector = VECTOR_BASE + idx×VECTOR_STRIDE; → IDLE.
- Cancelled dispatch: if Pending = 0 at i_Ack (IF/IE rewritten meanwhile), o_Vector = 16'h0000, no IF bit cleared, IME still cleared.
- DI while in REQ: return to IDLE, o_Irq drops next cycle.
- Priority resolves at ack time, not at REQ entry.

## Timing
- Reset: IE=0, IF=0, IME_OFF, FSM IDLE, o_Irq=0, o_Vector=0, o_Vector_Valid=0, edge history=0.
- o_Irq registered: high the cycle after REQ entry condition.
- o_Vector/o_Vector_Valid: cycle after i_Ack; o_Vector holds value until next dispatch.
- Same-cycle collisions: new request beats IF bus write and dispatch clear on the same bit; DI beats EI/RETI; bus IE/IF write affects the ack snapshot only from the following cycle.
- i_Enable low: no state changes, strobes ignored; outputs hold.
- Reset mid-dispatch: immediate return to reset values; no vector emitted.

## Configuration
- IRQ_EDGE_DETECT_EN defined: IF bit sets on rising edge of its request line (one registered history bit per source); held-high lines set IF once.
- Undefined: IF bit ORs in the raw level every enabled cycle (legacy behaviour); no history registers.

## Structure
- Package interrupt_pkg: IME and dispatch state enums, default VECTOR_BASE/VECTOR_STRIDE constants, cancelled-vector constant 16'h0000.
- Sub-module priority_encoder: NUM_SRC-wide lowest-set-bit one-hot plus binary index and valid.

## Test plan
- IE=5'h1F, IME_ON, request bits 2 and 4 together, i_Instr_Done, i_Ack → o_Vector=16'h0050, IF=5'h10, IME_OFF.
- EI strobe then i_Instr_Done with IE=IF=5'h01 → no o_Irq before boundary; o_Irq one cycle after following boundary.
- In REQ, bus write IF=0, then i_Ack → o_Vector=16'h0000, o_Vector_Valid=1, IF unchanged.
- Request on bit 1 same cycle as IF bus write 0 → IF=5'h02.
- IRQ_EDGE_DETECT_EN defined, bit 0 held high 10 cycles, IF cleared by write at cycle 3 → IF stays 0; undefined → IF re-sets next cycle.
- Reset asserted during VEC cycle, IF=5'h03 → all outputs 0 immediately, IF=0, IME_OFF.
